// File: rtl/axi_aw_issuer.sv
// AXI write-address issuer: accepts one request at a time, drives a single AW beat, tracks B retirements.
// AW outputs are registered one cycle after acceptance; illegal bursts are swallowed and flagged.
module axi_aw_issuer #(
  parameter int ADDR_W  = 32,
  parameter int ID_W    = 12,
  parameter int AXI_ID  = 0,
  parameter int MAX_OUT = 4,
  localparam int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [7:0]        req_len,
  input  logic [2:0]        req_size,
  input  logic [1:0]        req_burst,

  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic [7:0]        m_axi_awlen,
  output logic [2:0]        m_axi_awsize,
  output logic [1:0]        m_axi_awburst,
  output logic [ID_W-1:0]   m_axi_awid,
  output logic              m_axi_awlock,
  output logic [3:0]        m_axi_awcache,
  output logic [2:0]        m_axi_awprot,
  output logic [3:0]        m_axi_awqos,

  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  input  logic [ID_W-1:0]   m_axi_bid,
  input  logic [1:0]        m_axi_bresp,

  output logic [CNT_W-1:0]  outstanding,
  output logic              idle,
  output logic              err_resp,
  output logic              err_id,
  output logic              err_req,
  input  logic              err_clr
);

  typedef enum logic {IDLE, ADDR} state_t;

  localparam logic [ID_W-1:0]  ID_C      = ID_W'(AXI_ID);
  localparam logic [CNT_W-1:0] MAX_OUT_C = CNT_W'(MAX_OUT);

  state_t      state;
  logic        aw_hs;
  logic        b_hs;
  logic        req_hs;
  logic        req_bad;
  logic [16:0] burst_bytes;
  logic [16:0] burst_end;

  assign m_axi_awid    = ID_C;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'b0011;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awqos   = 4'b0000;

  assign req_ready    = (state == IDLE) && (outstanding < MAX_OUT_C) && !rst;
  assign m_axi_bready = (outstanding != '0);
  assign idle         = !m_axi_awvalid && (outstanding == '0);

  assign req_hs = req_valid && req_ready;
  assign aw_hs  = m_axi_awvalid && m_axi_awready;
  assign b_hs   = m_axi_bvalid && m_axi_bready;

  // An INCR burst may end exactly on the 4 KB boundary but not beyond it.
  assign burst_bytes = (17'(req_len) + 17'd1) << req_size;
  assign burst_end   = 17'(req_addr[11:0]) + burst_bytes;
  assign req_bad     = (req_burst == 2'b11) ||
                       ((req_burst == 2'b01) && (burst_end > 17'd4096));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      m_axi_awvalid <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_awlen   <= '0;
      m_axi_awsize  <= '0;
      m_axi_awburst <= '0;
      outstanding   <= '0;
      err_resp      <= 1'b0;
      err_id        <= 1'b0;
      err_req       <= 1'b0;
    end else begin
      if (err_clr) begin
        err_resp <= 1'b0;
        err_id   <= 1'b0;
        err_req  <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (req_hs) begin
            if (req_bad) begin
              err_req <= 1'b1;
            end else begin
              m_axi_awaddr  <= req_addr;
              m_axi_awlen   <= req_len;
              m_axi_awsize  <= req_size;
              m_axi_awburst <= req_burst;
              m_axi_awvalid <= 1'b1;
              state         <= ADDR;
            end
          end
        end
        ADDR: begin
          if (m_axi_awready) begin
            m_axi_awvalid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // A response with a foreign ID still retires one write.
      if (b_hs) begin
        if (m_axi_bresp != 2'b00) err_resp <= 1'b1;
        if (m_axi_bid != ID_C)    err_id   <= 1'b1;
      end

      case ({aw_hs, b_hs})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_aw_issuer.sv
// Bench for axi_aw_issuer: directed scenarios then random traffic, all checked each cycle against a
// transaction-level model (pending AW slot, outstanding count, sticky errors).
module tb_axi_aw_issuer;

  localparam int ADDR_W  = 32;
  localparam int ID_W    = 12;
  localparam int AXI_ID  = 0;
  localparam int MAX_OUT = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [7:0]        req_len = '0;
  logic [2:0]        req_size = '0;
  logic [1:0]        req_burst = '0;
  logic              m_axi_awvalid;
  logic              m_axi_awready = 1'b0;
  logic [ADDR_W-1:0] m_axi_awaddr;
  logic [7:0]        m_axi_awlen;
  logic [2:0]        m_axi_awsize;
  logic [1:0]        m_axi_awburst;
  logic [ID_W-1:0]   m_axi_awid;
  logic              m_axi_awlock;
  logic [3:0]        m_axi_awcache;
  logic [2:0]        m_axi_awprot;
  logic [3:0]        m_axi_awqos;
  logic              m_axi_bvalid = 1'b0;
  logic              m_axi_bready;
  logic [ID_W-1:0]   m_axi_bid = '0;
  logic [1:0]        m_axi_bresp = '0;
  logic [3:0]        outstanding;
  logic              idle;
  logic              err_resp;
  logic              err_id;
  logic              err_req;
  logic              err_clr = 1'b0;

  axi_aw_issuer #(
    .ADDR_W(ADDR_W), .ID_W(ID_W), .AXI_ID(AXI_ID), .MAX_OUT(MAX_OUT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_len(req_len), .req_size(req_size), .req_burst(req_burst),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
    .m_axi_awid(m_axi_awid), .m_axi_awlock(m_axi_awlock),
    .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot),
    .m_axi_awqos(m_axi_awqos),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp),
    .outstanding(outstanding), .idle(idle),
    .err_resp(err_resp), .err_id(err_id), .err_req(err_req), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Values to drive on the next cycle.
  bit          d_rst = 1'b1;
  bit          d_req_valid, d_awready, d_bvalid, d_err_clr;
  logic [31:0] d_addr;
  logic [7:0]  d_len;
  logic [2:0]  d_size;
  logic [1:0]  d_burst;
  logic [11:0] d_bid;
  logic [1:0]  d_bresp;

  // Model: at most one AW waiting, a count of unanswered writes, three sticky flags.
  bit          m_pend;
  logic [31:0] m_addr;
  logic [7:0]  m_len;
  logic [2:0]  m_size;
  logic [1:0]  m_burst;
  int          m_out;
  bit          m_er, m_ei, m_eq;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_bad(logic [31:0] a, logic [7:0] l, logic [2:0] s, logic [1:0] b);
    int span;
    span = (int'(l) + 1) * (1 << s);
    return (b == 2'b11) || (b == 2'b01 && int'(a & 32'hfff) + span > 4096);
  endfunction

  function automatic bit exp_ready();
    return !d_rst && !m_pend && (m_out < MAX_OUT);
  endfunction

  task automatic model_reset();
    m_pend = 0; m_addr = '0; m_len = '0; m_size = '0; m_burst = '0;
    m_out = 0; m_er = 0; m_ei = 0; m_eq = 0;
  endtask

  task automatic compare();
    bit r;
    r = d_rst;
    chk("awvalid",  64'(m_axi_awvalid), r ? 64'd0 : 64'(m_pend));
    chk("awaddr",   64'(m_axi_awaddr),  r ? 64'd0 : 64'(m_addr));
    chk("awlen",    64'(m_axi_awlen),   r ? 64'd0 : 64'(m_len));
    chk("awsize",   64'(m_axi_awsize),  r ? 64'd0 : 64'(m_size));
    chk("awburst",  64'(m_axi_awburst), r ? 64'd0 : 64'(m_burst));
    chk("outstanding", 64'(outstanding), r ? 64'd0 : 64'(m_out));
    chk("bready",   64'(m_axi_bready),  r ? 64'd0 : 64'(m_out != 0));
    chk("req_ready", 64'(req_ready),    64'(exp_ready()));
    chk("idle",     64'(idle),          r ? 64'd1 : 64'(!m_pend && m_out == 0));
    chk("err_resp", 64'(err_resp),      r ? 64'd0 : 64'(m_er));
    chk("err_id",   64'(err_id),        r ? 64'd0 : 64'(m_ei));
    chk("err_req",  64'(err_req),       r ? 64'd0 : 64'(m_eq));
    chk("aw_consts", {m_axi_awid, m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awqos},
        {12'(AXI_ID), 1'b0, 4'b0011, 3'b000, 4'b0000});
  endtask

  task automatic model_step();
    bit rh, awh, bh;
    if (d_rst) begin
      model_reset();
      return;
    end
    rh  = d_req_valid && exp_ready();
    awh = m_pend && d_awready;
    bh  = d_bvalid && (m_out != 0);
    if (d_err_clr) begin m_er = 0; m_ei = 0; m_eq = 0; end
    if (awh) begin m_pend = 0; m_out++; end
    if (bh) begin
      m_out--;
      if (d_bresp != 2'b00) m_er = 1;
      if (d_bid != 12'(AXI_ID)) m_ei = 1;
    end
    if (rh) begin
      if (is_bad(d_addr, d_len, d_size, d_burst)) m_eq = 1;
      else begin
        m_pend = 1; m_addr = d_addr; m_len = d_len; m_size = d_size; m_burst = d_burst;
      end
    end
  endtask

  // One cycle: drive at the falling edge, check just after, advance the model before the rising edge.
  task automatic step();
    @(negedge clk);
    rst = d_rst; req_valid = d_req_valid; req_addr = d_addr; req_len = d_len;
    req_size = d_size; req_burst = d_burst; m_axi_awready = d_awready;
    m_axi_bvalid = d_bvalid; m_axi_bid = d_bid; m_axi_bresp = d_bresp; err_clr = d_err_clr;
    #1;
    compare();
    model_step();
  endtask

  task automatic quiet();
    d_req_valid = 0; d_awready = 0; d_bvalid = 0; d_err_clr = 0;
    d_addr = '0; d_len = '0; d_size = '0; d_burst = 2'b01; d_bid = 12'(AXI_ID); d_bresp = '0;
  endtask

  task automatic do_reset();
    quiet();
    d_rst = 1;
    step();
    chk("lit_rst_req_ready", 64'(req_ready), 64'd0);
    chk("lit_rst_idle", 64'(idle), 64'd1);
    step();
    d_rst = 0;
  endtask

  task automatic set_req(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                         input logic [1:0] b);
    d_addr = a; d_len = l; d_size = s; d_burst = b;
  endtask

  initial begin
    model_reset();
    quiet();

    // Accept, then hold AW against three cycles of backpressure.
    do_reset();
    step();
    chk("lit_ready_after_rst", 64'(req_ready), 64'd1);
    set_req(32'h1000, 8'd3, 3'd3, 2'b01);
    d_req_valid = 1;
    step();
    d_req_valid = 0; set_req(32'h0, 8'd0, 3'd0, 2'b00);
    step();
    chk("lit_awvalid_lat1", 64'(m_axi_awvalid), 64'd1);
    chk("lit_awaddr", 64'(m_axi_awaddr), 64'h1000);
    step(); step();
    d_awready = 1;
    step();
    chk("lit_awaddr_held", 64'(m_axi_awaddr), 64'h1000);
    chk("lit_awlen_held", 64'(m_axi_awlen), 64'd3);
    d_awready = 0;
    step();
    chk("lit_out_1", 64'(outstanding), 64'd1);
    chk("lit_idle_0", 64'(idle), 64'd0);

    // Saturate at MAX_OUT, then free one slot with a B.
    do_reset();
    set_req(32'h2000, 8'd0, 3'd2, 2'b01);
    d_req_valid = 1; d_awready = 1;
    repeat (10) step();
    d_bvalid = 1;
    step();
    chk("lit_out_full", 64'(outstanding), 64'd4);
    chk("lit_ready_full", 64'(req_ready), 64'd0);
    d_bvalid = 0;
    step();
    chk("lit_out_3", 64'(outstanding), 64'd3);
    chk("lit_ready_3", 64'(req_ready), 64'd1);
    d_req_valid = 0;
    step(); step();
    chk("lit_out_refill", 64'(outstanding), 64'd4);

    // 4 KB crossing is swallowed and flagged.
    do_reset();
    set_req(32'h0FF8, 8'd1, 3'd3, 2'b01);
    d_req_valid = 1;
    step();
    d_req_valid = 0;
    step();
    chk("lit_err_req", 64'(err_req), 64'd1);
    chk("lit_no_aw", 64'(m_axi_awvalid), 64'd0);
    d_err_clr = 1;
    step();
    d_err_clr = 0;
    step();
    chk("lit_err_req_clr", 64'(err_req), 64'd0);

    // Simultaneous AW and B at outstanding 2, then a bad B.
    do_reset();
    set_req(32'h3000, 8'd7, 3'd2, 2'b01);
    d_req_valid = 1; d_awready = 1;
    repeat (5) step();
    d_req_valid = 0; d_bvalid = 1;
    step();
    d_bvalid = 0;
    step();
    chk("lit_out_same", 64'(outstanding), 64'd2);
    d_bvalid = 1; d_bresp = 2'b10; d_bid = 12'(AXI_ID + 1);
    step();
    quiet();
    step();
    chk("lit_err_resp", 64'(err_resp), 64'd1);
    chk("lit_err_id", 64'(err_id), 64'd1);
    chk("lit_out_dec", 64'(outstanding), 64'd1);

    // Reset mid-cycle while an AW waits and three writes are outstanding.
    do_reset();
    set_req(32'h4000, 8'd0, 3'd0, 2'b00);
    d_req_valid = 1; d_awready = 1;
    repeat (6) step();
    d_awready = 0;
    step();
    d_req_valid = 0;
    step();
    chk("lit_pre_rst_aw", 64'(m_axi_awvalid), 64'd1);
    chk("lit_pre_rst_out", 64'(outstanding), 64'd3);
    #2 rst = 1'b1; d_rst = 1;
    #1;
    chk("lit_async_aw", 64'(m_axi_awvalid), 64'd0);
    chk("lit_async_out", 64'(outstanding), 64'd0);
    chk("lit_async_idle", 64'(idle), 64'd1);
    step();
    d_rst = 0;

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      d_rst       = ($urandom_range(0, 199) == 0);
      d_req_valid = $urandom_range(0, 1);
      d_addr      = $urandom_range(0, 1) ? $urandom : (32'h0000_0F00 | 32'($urandom_range(0, 255)));
      d_len       = $urandom_range(0, 1) ? 8'($urandom_range(0, 7)) : 8'($urandom);
      d_size      = 3'($urandom);
      d_burst     = 2'($urandom);
      d_awready   = ($urandom_range(0, 2) != 0);
      d_bvalid    = $urandom_range(0, 1);
      d_bid       = ($urandom_range(0, 9) == 0) ? 12'($urandom) : 12'(AXI_ID);
      d_bresp     = ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b00;
      d_err_clr   = ($urandom_range(0, 19) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
